// File: rtl/adc_sequencer_pkg.sv
// Shared types and frame constants for the ADC sequencer.
package adc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_QUIET
    } state_e;

    localparam int FRAME_LEN = 16;
    localparam int DATA_W    = 12;
    localparam int DATA_MSB  = 11;
    localparam int BIT_CNT_W = 4;
    localparam int DIV_W     = 8;

    function automatic logic cs_active(input state_e st);
        return (st == ST_CS_SETUP) || (st == ST_SHIFT);
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK half-period divider: emits the SCLK level and a tick at each phase end.
// Parks SCLK high whenever disabled or when the final phase ends.
module adc_sclk_gen
    import adc_sequencer_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic last,
    output logic sclk,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    assign tick = enable && (cnt_q == DIV_LAST);
    assign sclk = sclk_q;

    always_comb begin
        cnt_d  = '0;
        sclk_d = 1'b1;
        if (enable) begin
            cnt_d  = tick ? '0 : cnt_q + DIV_W'(1);
            sclk_d = sclk_q;
            if (tick) begin
                sclk_d = last ? 1'b1 : ~sclk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// ADC frame sequencer: CS/SCLK framing, serial capture and auto-trigger.
// One 16-bit frame per trigger; the low 12 bits become data_Out.
module adc_sequencer
    import adc_sequencer_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8,
    parameter int PERIOD_W     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                SDATA,
    output logic                CS,
    output logic                SCLK,
    output logic                busy,
    output logic                data_valid,
    output logic [DATA_W-1:0]   data_Out,
    output logic                overrun
);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(FRAME_LEN - 1);
    localparam logic [7:0]           QUIET_LAST = 8'(QUIET_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]             quiet_cnt_q, quiet_cnt_d;
    logic [PERIOD_W-1:0]    timer_q, timer_d;
    logic [PERIOD_W-1:0]    per_q, per_d;
    logic [PERIOD_W-1:0]    eff_per;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   cs_q, cs_d;
    logic                   busy_q, busy_d;
    logic                   dv_q, dv_d;
    logic                   ovr_q, ovr_d;

    logic auto_on, expire, trigger;
    logic sclk_en, sclk_tick, sclk_lvl, last_phase;
    logic unused_msb;

    assign unused_msb = ^shift_q[FRAME_LEN-1:DATA_MSB+1];

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (sclk_en),
        .last    (last_phase),
        .sclk    (sclk_lvl),
        .tick    (sclk_tick)
    );

    assign sclk_en    = cs_active(state_q);
    assign last_phase = (state_q == ST_SHIFT) && sclk_lvl
                        && (bit_cnt_q == BIT_LAST);

    // Period is latched at each wrap so a new value waits for the next one.
    assign auto_on = auto_en && (period != '0);
    assign eff_per = (per_q == '0) ? period : per_q;
    assign expire  = auto_on && (timer_q == eff_per - PERIOD_W'(1));
    assign trigger = start || expire;

    always_comb begin
        timer_d = timer_q + PERIOD_W'(1);
        per_d   = per_q;
        if (!auto_on || expire) begin
            timer_d = '0;
            per_d   = period;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        data_d      = data_q;
        ovr_d       = trigger && (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d     = ST_CS_SETUP;
                    bit_cnt_d   = '0;
                    quiet_cnt_d = '0;
                end
            end
            ST_CS_SETUP: begin
                if (sclk_tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_tick) begin
                    if (!sclk_lvl) begin
                        shift_d = {shift_q[FRAME_LEN-2:0], SDATA};
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_CS_HOLD;
                        data_d  = shift_q[DATA_MSB:0];
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            // The hold cycle is the first of the quiet window.
            ST_CS_HOLD: begin
                quiet_cnt_d = 8'd1;
                state_d     = (QUIET_CYCLES > 1) ? ST_QUIET : ST_IDLE;
            end
            ST_QUIET: begin
                if (quiet_cnt_q >= QUIET_LAST) begin
                    state_d     = ST_IDLE;
                    quiet_cnt_d = '0;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cs_d   = !cs_active(state_d);
        busy_d = (state_d != ST_IDLE);
        dv_d   = (state_d == ST_CS_HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            timer_q     <= '0;
            per_q       <= '0;
            data_q      <= '0;
            cs_q        <= 1'b1;
            busy_q      <= 1'b0;
            dv_q        <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            timer_q     <= timer_d;
            per_q       <= per_d;
            data_q      <= data_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
            dv_q        <= dv_d;
            ovr_q       <= ovr_d;
        end
    end

    assign CS         = cs_q;
    assign SCLK       = sclk_lvl;
    assign busy       = busy_q;
    assign data_valid = dv_q;
    assign data_Out   = data_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: framing, latency, overrun, auto-trigger.
// Instance a runs CLK_DIV=2; instance b runs CLK_DIV=1 with a short period.
module tb_adc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] period = 16'd0;
    logic        sdata = 1'b0;
    logic        cs, sclk, busy, dv, ovr;
    logic [11:0] dout;

    logic        b_start = 1'b0;
    logic        b_auto = 1'b0;
    logic [15:0] b_period = 16'd0;
    logic        b_sdata = 1'b1;
    logic        b_cs, b_sclk, b_busy, b_dv, b_ovr;
    logic [11:0] b_dout;

    adc_sequencer #(
        .CLK_DIV(2), .QUIET_CYCLES(8), .PERIOD_W(16)
    ) dut_a (
        .clk(clk), .reset_n(rst_n), .start(start), .auto_en(auto_en),
        .period(period), .SDATA(sdata), .CS(cs), .SCLK(sclk),
        .busy(busy), .data_valid(dv), .data_Out(dout), .overrun(ovr)
    );

    adc_sequencer #(
        .CLK_DIV(1), .QUIET_CYCLES(8), .PERIOD_W(16)
    ) dut_b (
        .clk(clk), .reset_n(rst_n), .start(b_start), .auto_en(b_auto),
        .period(b_period), .SDATA(b_sdata), .CS(b_cs), .SCLK(b_sclk),
        .busy(b_busy), .data_valid(b_dv), .data_Out(b_dout),
        .overrun(b_ovr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: word shifted out MSB-first, a new bit on each SCLK fall.
    logic [15:0] adc_word = 16'h0;
    int          adc_idx = 15;
    always @(negedge cs) adc_idx = 15;
    always @(negedge sclk) begin
        if (!cs && adc_idx >= 0) begin
            sdata = adc_word[adc_idx[3:0]];
            adc_idx = adc_idx - 1;
        end
    end

    int   dv_cnt = 0, ovr_cnt = 0, last_dv = 0;
    int   a_falls[$];
    logic cs_prev = 1'b1;
    always @(negedge clk) begin
        if (dv === 1'b1) begin
            dv_cnt++;
            last_dv = cyc;
        end
        if (ovr === 1'b1) ovr_cnt++;
        if (cs_prev === 1'b1 && cs === 1'b0) a_falls.push_back(cyc);
        cs_prev = cs;
    end

    int   b_dv_cnt = 0, b_ovr_cnt = 0;
    int   b_falls[$];
    logic b_cs_prev = 1'b1, b_busy_prev = 1'b0;
    always @(negedge clk) begin
        if (b_dv === 1'b1) b_dv_cnt++;
        if (b_ovr === 1'b1) b_ovr_cnt++;
        if (b_cs_prev === 1'b1 && b_cs === 1'b0) begin
            b_falls.push_back(cyc);
            check("b_start_from_idle", 32'(b_busy_prev), 32'd0);
        end
        b_cs_prev = b_cs;
        b_busy_prev = b_busy;
    end

    task automatic wait_dv(input int target);
        for (int i = 0; i < 300 && dv_cnt < target; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
        check(tag, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic one_frame(input logic [15:0] word, input string tag,
                             input logic [11:0] exp);
        int t0, n0;
        adc_word = word;
        n0 = dv_cnt;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dv(n0 + 1);
        check({tag, "_dv"}, 32'(dv_cnt), 32'(n0 + 1));
        check({tag, "_lat"}, 32'(last_dv - t0), 32'd67);
        check({tag, "_data"}, 32'(dout), 32'(exp));
        repeat (20) @(negedge clk);
        check({tag, "_hold"}, 32'(dout), 32'(exp));
        check({tag, "_dv_low"}, 32'(dv), 32'd0);
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        int t0, n0, o0;

        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dv", 32'(dv), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame with phase checks along the way.
        adc_word = 16'h0ABC;
        n0 = dv_cnt;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s1_cs_low", 32'(cs), 32'd0);
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_sclk_setup", 32'(sclk), 32'd1);
        repeat (2) @(negedge clk);
        check("s1_sclk_low", 32'(sclk), 32'd0);
        wait_dv(n0 + 1);
        check("s1_dv", 32'(dv_cnt), 32'(n0 + 1));
        check("s1_lat", 32'(last_dv - t0), 32'd67);
        check("s1_data", 32'(dout), 32'hABC);
        wait_idle("s1_idle");

        // Second start ten cycles into a frame is dropped.
        adc_word = 16'h0DEF;
        n0 = dv_cnt;
        o0 = ovr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dv(n0 + 1);
        check("s3_data", 32'(dout), 32'hDEF);
        wait_idle("s3_idle");
        repeat (100) @(negedge clk);
        check("s3_dv_once", 32'(dv_cnt - n0), 32'd1);
        check("s3_ovr_once", 32'(ovr_cnt - o0), 32'd1);

        // Reset at the eighth SCLK edge aborts the frame.
        adc_word = 16'h0555;
        n0 = dv_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("s4_cs_pre", 32'(cs), 32'd0);
        rst_n = 1'b0;
        #1;
        check("s4_cs_async", 32'(cs), 32'd1);
        check("s4_sclk_async", 32'(sclk), 32'd1);
        check("s4_busy_async", 32'(busy), 32'd0);
        check("s4_dout_clr", 32'(dout), 32'd0);
        repeat (3) @(negedge clk);
        check("s4_no_dv", 32'(dv_cnt), 32'(n0));
        adc_word = 16'h0321;
        t0 = cyc;
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s4_first_edge", 32'(cs), 32'd0);
        wait_dv(n0 + 1);
        check("s4_lat", 32'(last_dv - t0), 32'd67);
        check("s4_data", 32'(dout), 32'h321);
        wait_idle("s4_idle");

        one_frame(16'hFFFF, "s6_ones", 12'hFFF);
        one_frame(16'h0000, "s6_zeros", 12'h000);

        // Auto-trigger every 200 cycles.
        a_falls.delete();
        o0 = ovr_cnt;
        period = 16'd200;
        @(negedge clk);
        t0 = cyc;
        auto_en = 1'b1;
        for (int i = 0; i < 1500 && a_falls.size() < 5; i++) @(negedge clk);
        auto_en = 1'b0;
        check("s2_frames", 32'(a_falls.size()), 32'd5);
        if (a_falls.size() > 0)
            check("s2_first", 32'(a_falls[0] - t0), 32'd200);
        for (int k = 1; k < a_falls.size(); k++)
            check("s2_spacing", 32'(a_falls[k] - a_falls[k-1]), 32'd200);
        check("s2_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        wait_idle("s2_idle");

        // Period shorter than a frame: alternate expiries overrun.
        b_period = 16'd40;
        @(negedge clk);
        t0 = cyc;
        b_auto = 1'b1;
        for (int i = 0; i < 400 && b_falls.size() < 3; i++) @(negedge clk);
        b_auto = 1'b0;
        check("s5_frames", 32'(b_falls.size()), 32'd3);
        if (b_falls.size() > 0)
            check("s5_first", 32'(b_falls[0] - t0), 32'd40);
        for (int k = 1; k < b_falls.size(); k++)
            check("s5_spacing", 32'(b_falls[k] - b_falls[k-1]), 32'd80);
        check("s5_ovr", 32'(b_ovr_cnt), 32'd2);
        check("s5_dv", 32'(b_dv_cnt), 32'd2);
        check("s5_data", 32'(b_dout), 32'hFFF);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_sequencer.md
ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 The block SHALL be clocked by one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 1..255.
REQ-003 Parameter QUIET_CYCLES, default 8: minimum CS-high clk cycles between frames, legal range 1..255.
REQ-004 Parameter PERIOD_W, default 16: width of the auto-trigger period input.
REQ-005 Ports SHALL be as listed:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- start  in  1  single-cycle conversion request
- auto_en  in  1  enable periodic conversions
- period  in  PERIOD_W  auto-trigger interval in clk cycles, 0 = auto disabled
- SDATA  in  1  serial data from ADC
- CS  out  1  ADC chip select, active low
- SCLK  out  1  serial clock to ADC, idle high
- busy  out  1  frame in progress (CS_SETUP..QUIET)
- data_valid  out  1  one-cycle pulse, data_Out updated
- data_Out  out  12  last converted sample
- overrun  out  1  one-cycle pulse, trigger dropped while busy

Function
REQ-006 FSM states SHALL be IDLE, CS_SETUP, SHIFT, CS_HOLD, QUIET.
REQ-007 IDLE -> CS_SETUP on a trigger: start=1, or auto-timer expiry with auto_en=1 and period!=0; CS SHALL go low in the cycle after the trigger is sampled.
REQ-008 CS_SETUP SHALL last CLK_DIV cycles with SCLK high, then go to SHIFT.
REQ-009 SHIFT SHALL generate 16 SCLK periods, each being CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-010 SDATA SHALL be sampled into a 16-bit MSB-first shift register on the clk edge ending each SCLK-low phase, i.e. at the SCLK rising edge.
REQ-011 After the 16th high phase the FSM SHALL enter CS_HOLD for exactly one cycle: CS high, data_Out <= shift[11:0], data_valid=1.
REQ-012 Leading bits shift[15:12] SHALL be discarded without checking.
REQ-013 QUIET SHALL hold CS high for QUIET_CYCLES cycles, counted including the CS_HOLD cycle, then return to IDLE.
REQ-014 Trigger-to-data_valid latency SHALL be 1 + CLK_DIV + 32*CLK_DIV clk cycles.
REQ-015 A trigger arriving while busy=1 SHALL be dropped and SHALL pulse overrun for one cycle; start and timer expiry in the same cycle SHALL count as one trigger.
REQ-016 The auto-timer SHALL count clk cycles from 0 and expire at period-1, then wrap to 0; it SHALL free-run regardless of busy.
REQ-017 The auto-timer SHALL be cleared whenever auto_en=0 or period=0.
REQ-018 A change to period SHALL take effect at the next wrap.
REQ-019 data_Out SHALL hold its value between data_valid pulses.
REQ-020 SCLK SHALL be high in every state except SHIFT low phases; CS SHALL be low only in CS_SETUP and SHIFT.

Reset
REQ-021 While reset_n=0, the block SHALL be in IDLE with CS=1, SCLK=1, busy=0, data_valid=0, overrun=0, data_Out=0, shift register=0, and all counters=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, with no data_valid and CS high asynchronously.
REQ-023 After reset release the first trigger SHALL be accepted on the first clk edge.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, the frame length constant (16), the data width constant (12), and the data MSB index (11).
REQ-025 The SCLK half-period tick counter SHALL be a sub-module adc_sclk_gen (enable, CLK_DIV) emitting SCLK level and phase-end tick.
REQ-026 Shift register, bit counter, quiet counter and auto-timer SHALL live in adc_sequencer.

Verification
REQ-027 Scenario: CLK_DIV=2, start pulse, ADC model drives 0x0ABC MSB-first on SCLK falling edges -> data_Out=0xABC and data_valid high exactly 67 cycles after start.
REQ-028 Scenario: auto_en=1, period=200, CLK_DIV=2, QUIET_CYCLES=8 -> CS falling edges exactly 200 cycles apart over 5 frames, with no overrun.
REQ-029 Scenario: start pulse at cycle 10 of a frame -> overrun pulses once and only one data_valid results.
REQ-030 Scenario: reset_n low at SCLK edge 8 -> CS=1 and SCLK=1 immediately, no data_valid, data_Out=0; the next start completes normally.
REQ-031 Scenario: period=40 (shorter than a frame), CLK_DIV=1 -> every expiry during busy pulses overrun and frames start only from IDLE.
REQ-032 Scenario: ADC model returns 0xFFFF then 0x0000 -> data_Out=0xFFF then 0x000 with each value held between pulses.
